display_byte_scheduler: RTL and testbench

Time-shares the board's single 3-digit hex display among up to four 8-bit probe sources, so one bitstream can show IO_P6, IO_P7, DPSwitch and Switch values in turn. It sits between the probe input pins and the hex display driver and produces the byte that driver shows. It rotates automatically on a dwell timer, skips sources marked invalid, and takes two push-buttons: step to the next source, and freeze or resume rotation.

---
 rtl/display_sched_pkg.sv | 12 +
 rtl/button_debounce.sv | 29 ++
 rtl/display_byte_scheduler.sv | 89 ++++++++
 tb/tb_display_byte_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_sched_pkg.sv
// display_sched_pkg: state encoding, source count and next-valid search for display_byte_scheduler
package display_sched_pkg;
  typedef enum logic {SCAN = 1'b0, HOLD = 1'b1} state_t;
  localparam int NUM_SRC = 4;
  function automatic logic [1:0] next_valid(input logic [1:0] sel, input logic [NUM_SRC-1:0] valid);
    logic [1:0] r;
    r = sel;
    for (int i = NUM_SRC - 1; i >= 1; i--)
      if (valid[sel + 2'(i)]) r = sel + 2'(i);
    return r;
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser, stable-time filter and one-cycle press event for an active-low button
module button_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);
  localparam int W = $clog2(CYCLES + 1);
  logic s1, s2, db, done;
  logic [W-1:0] cnt;
  assign done = s2 != db && cnt == W'(CYCLES - 1);
  // Accept a new level only after it has differed from the filtered level for CYCLES cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      db <= 1'b1;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
      cnt <= (s2 == db || done) ? '0 : cnt + 1'b1;
      db <= done ? s2 : db;
      press <= done && !s2;
    end
endmodule

// File: rtl/display_byte_scheduler.sv
// display_byte_scheduler: time-shares one hex display among four probe bytes; DISPLAY_SCHED_CHANGE_DETECT_EN adds jump-on-change
module display_byte_scheduler
  import display_sched_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int DWELL_MS = 1000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic        CLK_100MHz,
  input  logic        RST_n,
  input  logic [31:0] src_bytes,
  input  logic [3:0]  src_valid,
  input  logic        next_btn_n,
  input  logic        hold_btn_n,
  output logic [7:0]  display_byte,
  output logic [1:0]  src_index,
  output logic        hold_active,
  output logic        none_valid,
  output logic        src_changed
);
  localparam int TICK_N = SYS_CLK_FREQ / 1000;
  localparam int TW = $clog2(TICK_N) + 1;
  localparam int DW = $clog2(DWELL_MS) + 1;
  state_t state, nstate;
  logic [TW-1:0] tick_cnt;
  logic [DW-1:0] dwell;
  logic [1:0] sel, nxt, chg_idx;
  logic tick, expiry, adv, next_press, hold_press, chg_hit;
  button_debounce #(.CYCLES(DEBOUNCE_MS * TICK_N)) u_next (
    .clk(CLK_100MHz), .rst_n(RST_n), .btn_n(next_btn_n), .press(next_press)
  );
  button_debounce #(.CYCLES(DEBOUNCE_MS * TICK_N)) u_hold (
    .clk(CLK_100MHz), .rst_n(RST_n), .btn_n(hold_btn_n), .press(hold_press)
  );
  assign tick = tick_cnt == TW'(TICK_N - 1);
  assign expiry = state == SCAN && tick && dwell == DW'(DWELL_MS - 1);
  assign adv = expiry || next_press || !src_valid[sel];
  assign nxt = next_valid(sel, src_valid);
  assign nstate = hold_press ? (state == SCAN ? HOLD : SCAN) : state;
  assign src_index = sel;
  assign hold_active = state == HOLD;
`ifdef DISPLAY_SCHED_CHANGE_DETECT_EN
  logic [31:0] shadow;
  logic primed;
  // Keep last cycle's bytes; primed blocks a false change on the first cycle out of reset
  always_ff @(posedge CLK_100MHz or negedge RST_n)
    if (!RST_n) begin
      shadow <= '0;
      primed <= 1'b0;
    end else begin
      shadow <= src_bytes;
      primed <= 1'b1;
    end
  // Lowest-index valid, unselected source whose byte moved, only while scanning
  always_comb begin
    chg_hit = 1'b0;
    chg_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (primed && state == SCAN && src_valid[k] && 2'(k) != sel && src_bytes[8*k +: 8] != shadow[8*k +: 8]) begin
        chg_hit = 1'b1;
        chg_idx = 2'(k);
      end
  end
`else
  assign chg_hit = 1'b0;
  assign chg_idx = '0;
`endif
  // Free-running 1 ms strobe
  always_ff @(posedge CLK_100MHz or negedge RST_n)
    if (!RST_n) tick_cnt <= '0;
    else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  // Scan/hold state, selection, dwell timing and registered display outputs
  always_ff @(posedge CLK_100MHz or negedge RST_n)
    if (!RST_n) begin
      state <= SCAN;
      sel <= '0;
      dwell <= '0;
      display_byte <= 8'h00;
      none_valid <= 1'b0;
      src_changed <= 1'b0;
    end else begin
      state <= nstate;
      sel <= chg_hit ? chg_idx : adv ? nxt : sel;
      dwell <= (state == HOLD || nstate == HOLD || chg_hit || next_press || expiry) ? '0 : dwell + DW'(tick);
      display_byte <= src_valid == 4'h0 ? 8'h00 : src_bytes[{sel, 3'b000} +: 8];
      none_valid <= src_valid == 4'h0;
      src_changed <= chg_hit;
    end
endmodule

// File: tb/tb_display_byte_scheduler.sv
// tb_display_byte_scheduler: table, directed and randomized model-checked bench for display_byte_scheduler
module tb_display_byte_scheduler;
  localparam int DWELL = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] src_bytes = 32'h44332211;
  logic [3:0] src_valid = 4'hF;
  logic next_n = 1'b1;
  logic hold_n = 1'b1;
  logic [7:0] display_byte;
  logic [1:0] src_index;
  logic hold_active, none_valid, src_changed;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int m_e, m_sel, m_ticks;
  logic m_hold, m_none, m_chg;
  logic [7:0] m_disp;
  logic [5:0] n_hist, h_hist;
  logic n_db, h_db, n_prs, h_prs;
`ifdef DISPLAY_SCHED_CHANGE_DETECT_EN
  logic [31:0] m_prev;
  logic m_primed;
`endif
  typedef struct {int cyc; logic [1:0] idx; logic [7:0] disp;} vec_t;
  vec_t tbl [10];

  display_byte_scheduler #(.SYS_CLK_FREQ(4000), .DWELL_MS(DWELL), .DEBOUNCE_MS(1)) dut (
    .CLK_100MHz(clk),
    .RST_n(rst_n),
    .src_bytes(src_bytes),
    .src_valid(src_valid),
    .next_btn_n(next_n),
    .hold_btn_n(hold_n),
    .display_byte(display_byte),
    .src_index(src_index),
    .hold_active(hold_active),
    .none_valid(none_valid),
    .src_changed(src_changed)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_e = 0;
    m_sel = 0;
    m_ticks = 0;
    m_hold = 1'b0;
    m_none = 1'b0;
    m_chg = 1'b0;
    m_disp = 8'h00;
    n_hist = 6'h3F;
    h_hist = 6'h3F;
    n_db = 1'b1;
    h_db = 1'b1;
    n_prs = 1'b0;
    h_prs = 1'b0;
`ifdef DISPLAY_SCHED_CHANGE_DETECT_EN
    m_prev = '0;
    m_primed = 1'b0;
`endif
  endtask

  // One clock edge of the reference: a button level counts after 2 sync samples plus 4 stable samples,
  // the press acts one edge later; dwell counts whole ms ticks since the last restart.
  task automatic model_step();
    logic tk, np, hp, ex, chg, nh, found;
    int cidx, old;
    m_e++;
    tk = (m_e % 4) == 0;
    np = n_prs;
    hp = h_prs;
    n_hist = {n_hist[4:0], next_n};
    n_prs = 1'b0;
    if (n_hist[5:2] == {4{~n_db}}) begin
      n_db = ~n_db;
      n_prs = ~n_db;
    end
    h_hist = {h_hist[4:0], hold_n};
    h_prs = 1'b0;
    if (h_hist[5:2] == {4{~h_db}}) begin
      h_db = ~h_db;
      h_prs = ~h_db;
    end
    chg = 1'b0;
    cidx = 0;
`ifdef DISPLAY_SCHED_CHANGE_DETECT_EN
    if (m_primed && !m_hold)
      for (int k = 3; k >= 0; k--)
        if (src_valid[k] && k != m_sel && src_bytes[8*k +: 8] != m_prev[8*k +: 8]) begin
          chg = 1'b1;
          cidx = k;
        end
    m_prev = src_bytes;
    m_primed = 1'b1;
`endif
    ex = !m_hold && tk && m_ticks == DWELL - 1;
    old = m_sel;
    if (chg) m_sel = cidx;
    else if (ex || np || !src_valid[old]) begin
      found = 1'b0;
      for (int i = 1; i <= 4; i++)
        if (!found && src_valid[(old + i) % 4]) begin
          m_sel = (old + i) % 4;
          found = 1'b1;
        end
    end
    nh = m_hold ^ hp;
    if (m_hold || nh || chg || np || ex) m_ticks = 0;
    else if (tk) m_ticks++;
    m_hold = nh;
    m_disp = src_valid == 4'h0 ? 8'h00 : src_bytes[8*old +: 8];
    m_none = src_valid == 4'h0;
    m_chg = chg;
  endtask

  task automatic tick1();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    total++;
    if ({display_byte, src_index, hold_active, none_valid, src_changed} !== {m_disp, 2'(m_sel), m_hold, m_none, m_chg}) begin
      bad++;
      $display("FAIL model cyc=%0d: got disp=%h idx=%0d hold=%b none=%b chg=%b want disp=%h idx=%0d hold=%b none=%b chg=%b",
               cyc, display_byte, src_index, hold_active, none_valid, src_changed, m_disp, m_sel, m_hold, m_none, m_chg);
    end
  endtask

  initial begin
    int w, s, n, prev, k;
    tbl[0] = '{1, 2'd0, 8'h11};
    tbl[1] = '{7, 2'd0, 8'h11};
    tbl[2] = '{8, 2'd1, 8'h11};
    tbl[3] = '{9, 2'd1, 8'h22};
    tbl[4] = '{16, 2'd2, 8'h22};
    tbl[5] = '{17, 2'd2, 8'h33};
    tbl[6] = '{24, 2'd3, 8'h33};
    tbl[7] = '{25, 2'd3, 8'h44};
    tbl[8] = '{32, 2'd0, 8'h44};
    tbl[9] = '{33, 2'd0, 8'h11};
    model_reset();
    #12;
    chk("reset_outputs", {19'd0, display_byte, src_index, hold_active, none_valid, src_changed}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      while (cyc < tbl[i].cyc) tick1();
      chk($sformatf("rot_idx_c%0d", tbl[i].cyc), src_index, tbl[i].idx);
      chk($sformatf("rot_disp_c%0d", tbl[i].cyc), display_byte, tbl[i].disp);
    end
    src_valid = 4'b0101;
    n = 0;
    w = 0;
    for (int i = 0; i < 40; i++) begin
      tick1();
      if (src_index == 2'd1 || src_index == 2'd3) n++;
      if (src_index == 2'd2) w++;
    end
    chk("skip_only_0_2", n, 0);
    chk("skip_reaches_2", w != 0, 1);
    w = 0;
    while (src_index != 2'd2 && w < 20) begin
      tick1();
      w++;
    end
    chk("skip_at_2", src_index, 2);
    src_valid = 4'b0001;
    tick1();
    chk("drop_sel_to_0", src_index, 0);
    src_valid = 4'hF;
    hold_n = 1'b0;
    w = 0;
    while (!hold_active && w < 12) begin
      tick1();
      w++;
    end
    chk("hold_latency", w, 7);
    hold_n = 1'b1;
    s = src_index;
    n = 0;
    for (int i = 0; i < 120; i++) begin
      tick1();
      if (src_index != 2'(s)) n++;
    end
    chk("hold_freeze", n, 0);
    chk("hold_still_on", hold_active, 1);
    s = src_index;
    next_n = 1'b0;
    repeat (6) tick1();
    chk("next_not_early", src_index, s);
    tick1();
    chk("next_step", src_index, (s + 1) % 4);
    next_n = 1'b1;
    repeat (20) tick1();
    chk("next_single", src_index, (s + 1) % 4);
    s = src_index;
    prev = s;
    n = 0;
    for (int i = 0; i < 43; i++) begin
      next_n = (i == 1 || i >= 23) ? 1'b1 : 1'b0;
      tick1();
      if (src_index != 2'(prev)) n++;
      prev = src_index;
    end
    chk("bounce_one_advance", n, 1);
    chk("bounce_sel", src_index, (s + 1) % 4);
    while (cyc % 4 != 1) tick1();
    hold_n = 1'b0;
    repeat (7) tick1();
    chk("resume_scan", hold_active, 0);
    hold_n = 1'b1;
    s = src_index;
    repeat (7) tick1();
    chk("resume_no_early_step", src_index, s);
    tick1();
    chk("resume_step_at_8", src_index, (s + 1) % 4);
    src_valid = 4'h0;
    repeat (2) tick1();
    chk("none_flag", none_valid, 1);
    chk("none_display", display_byte, 0);
    s = src_index;
    repeat (5) tick1();
    chk("none_sel_holds", src_index, s);
    src_valid = 4'b1000;
    w = 0;
    while (src_index != 2'd3 && w < 4) begin
      tick1();
      w++;
    end
    chk("first_valid_sel", src_index, 3);
    chk("first_valid_within_2", w <= 2, 1);
    tick1();
    chk("none_cleared", none_valid, 0);
    src_valid = 4'hF;
    w = 0;
    while (src_index != 2'd0 && w < 40) begin
      tick1();
      w++;
    end
    chk("chg_start_sel0", src_index, 0);
    src_bytes[23:16] = 8'h5A;
    tick1();
`ifdef DISPLAY_SCHED_CHANGE_DETECT_EN
    chk("chg_jump", src_index, 2);
    chk("chg_pulse", src_changed, 1);
    tick1();
    chk("chg_pulse_one_cycle", src_changed, 0);
    repeat (3) tick1();
    chk("chg_dwell_restarted", src_index, 2);
`else
    chk("nochg_sel", src_index, 0);
    chk("nochg_pulse", src_changed, 0);
    tick1();
    chk("nochg_pulse_later", src_changed, 0);
`endif
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) src_valid = 4'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, 3);
        src_bytes[8*k +: 8] = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0) next_n = ~next_n;
      if ($urandom_range(0, 12) == 0) hold_n = ~hold_n;
      tick1();
    end
    next_n = 1'b1;
    hold_n = 1'b1;
    src_valid = 4'hF;
    repeat (5) tick1();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", {19'd0, display_byte, src_index, hold_active, none_valid, src_changed}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    tick1();
    chk("post_reset_idx", src_index, 0);
    chk("post_reset_disp", display_byte, src_bytes[7:0]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
